ship_placer: RTL and testbench
==============================

Name: ship_placer

Overview:
- Sequences ship placement for one player's board during the setup phase of the game.
- Accepts a placement request (bow row/col, direction) for the next ship in the fleet.
- Checks bounds, then scans the game board memory for overlap. If the placement is legal, writes SHIP cells to the board and a ship record to ship storage.
- Sits between the top-level controller FSM and one gb_mem / ss_mem pair; one instance per player.

Parameters:
- BOARD_DIM, 10, rows/columns on the board (valid coords 0..BOARD_DIM-1).
- COORD_W, 4, width of row/col coordinates.
- NUM_SHIPS, 5, ships per fleet; lengths come from the package table SHIP_LEN = {5,4,3,3,2}, indexed by ship_idx.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- clear  in  1  synchronous new-game restart of the placement count; honoured only in IDLE.
- req_valid  in  1  placement request valid.
- req_ready  out  1  high only in IDLE when clear=0.
- req_row, req_col  in  COORD_W  bow coordinate.
- req_dir  in  1  0 = horizontal (col increments), 1 = vertical (row increments).
- resp_valid  out  1  one-cycle pulse per accepted request.
- resp_code  out  2  00 OK, 01 OUT_OF_BOUNDS, 10 OVERLAP, 11 FLEET_FULL.
- ship_idx  out  3  number of ships placed so far (0..NUM_SHIPS).
- all_placed  out  1  ship_idx == NUM_SHIPS.
- gb_re, gb_we  out  1  board memory read/write enable.
- gb_row, gb_col  out  COORD_W  board cell address.
- gb_wdata  out  2  always CELL_SHIP (2'b11) when gb_we=1.
- gb_rdata  in  2  board read data, valid one cycle after gb_re.
- ss_we  out  1  ship storage write enable.
- ss_addr  out  3  = ship_idx at write time.
- ss_wdata  out  13  {row[3:0], col[3:0], dir, hits=3'b000, sunk=1'b0}.

Behaviour:
- Reset values: state IDLE; ship_idx 0; resp_valid, gb_re, gb_we, ss_we all 0; addresses 0; resp_code 00.
- The request is captured on the clock edge where req_valid && req_ready. Cycle numbers below count from that edge (acceptance = cycle 0). len = SHIP_LEN[ship_idx]; k = cell index 0..len-1.
- IDLE:
  - clear=1: ship_idx <- 0, no request accepted.
  - Else on accept: go to FULL_RESP if all_placed, otherwise BOUNDS.
- FULL_RESP: resp_valid=1, code FLEET_FULL (cycle 1); next IDLE.
- BOUNDS: compute the far end in COORD_W+1 bits. Legal iff row<BOARD_DIM, col<BOARD_DIM and end coord <= BOARD_DIM-1. Legal -> RD (k=0); illegal -> RESP with OUT_OF_BOUNDS (resp at cycle 2).
- RD: gb_re=1, address = bow + k along dir; next CHK.
- CHK: gb_rdata valid.
  - == CELL_SHIP -> RESP with OVERLAP.
  - Else if k==len-1 -> WR with k=0; otherwise k++ and back to RD.
  - OVERLAP for cell k responds at cycle 2k+4.
- WR: gb_we=1, gb_wdata=11, address of cell k, one cell per cycle; after k==len-1 go to STORE.
- STORE: ss_we=1, ss_addr=ship_idx; ship_idx increments at end of cycle; next RESP.
- RESP: resp_valid=1 for exactly one cycle with the latched code; next IDLE.
- Latency: OK response at cycle 3*len+3 (ship length 5 -> cycle 18).
- At most one of gb_re / gb_we / ss_we is high in any cycle.
- Cells holding MISS/HIT (01/10) are not overlap; only 11 blocks placement.
- Requests are not queued. req_ready stays low from acceptance through the RESP cycle; req_valid may stay high and is re-sampled in IDLE.
- Async reset mid-placement: returns to IDLE immediately, ship_idx 0. Partially written board cells are not rolled back; the board memory reset clears them.
- clear outside IDLE is ignored.

Optional Feature:
- Macro PLACER_STATS_EN.
- Defined: adds output rej_count[7:0], reset 0. It increments on each OUT_OF_BOUNDS or OVERLAP response, saturates at 255, and is zeroed by clear in IDLE.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package battleship_pkg holds:
  - BOARD_DIM, NUM_SHIPS and the SHIP_LEN table.
  - Cell enum: EMPTY 00, MISS 01, HIT 10, SHIP 11.
  - Response-code enum.
  - Placer state enum.
  - Packed ship-record struct (13 bits).
- One natural sub-module: placer_cell_addr. It holds the k counter and generates gb_row/gb_col from bow, dir and k, with a last-cell flag.

Test Plan:
- Empty board, ship 0, bow (2,3), dir 0 -> gb_we at cells (2,3)..(2,7); ss_wdata={2,3,0,000,0}; resp OK at cycle 18; ship_idx 1.
- Ship 0, bow (0,6), dir 0 -> OUT_OF_BOUNDS at cycle 2, no gb_re/gb_we, ship_idx stays 0.
- Ship 0 at (2,3) dir 0, then ship 1 (len 4) at (0,5) dir 1 -> reads (0,5),(1,5),(2,5); (2,5)=11 -> OVERLAP at cycle 8, no writes.
- Place all 5 ships legally -> all_placed=1; a 6th request -> FLEET_FULL at cycle 1; clear in IDLE -> ship_idx 0, all_placed 0.
- Assert reset=0 during WR of ship 2 -> all outputs at reset values immediately, state IDLE, req_ready high after release.
- With PLACER_STATS_EN defined: 3 illegal requests then 1 legal -> rej_count 3; clear -> 0.

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared constants, enums and the ship record for the battleship placement logic.
package battleship_pkg;

   localparam int BOARD_DIM = 10;
   localparam int COORD_W   = 4;
   localparam int NUM_SHIPS = 5;

   typedef enum logic [1:0] {
      CELL_EMPTY = 2'b00,
      CELL_MISS  = 2'b01,
      CELL_HIT   = 2'b10,
      CELL_SHIP  = 2'b11
   } cell_e;

   typedef enum logic [1:0] {
      RESP_OK      = 2'b00,
      RESP_OOB     = 2'b01,
      RESP_OVERLAP = 2'b10,
      RESP_FULL    = 2'b11
   } resp_code_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FULL_RESP,
      ST_BOUNDS,
      ST_RD,
      ST_CHK,
      ST_WR,
      ST_STORE,
      ST_RESP
   } placer_state_e;

   typedef struct packed {
      logic [3:0] row;
      logic [3:0] col;
      logic       dir;
      logic [2:0] hits;
      logic       sunk;
   } ship_rec_t;

   // SHIP_LEN table {5,4,3,3,2}, indexed by ship number.
   function automatic logic [2:0] ship_len(input logic [2:0] idx);
      logic [2:0] len;
      case (idx)
         3'd0:    len = 3'd5;
         3'd1:    len = 3'd4;
         3'd2:    len = 3'd3;
         3'd3:    len = 3'd3;
         3'd4:    len = 3'd2;
         default: len = 3'd0;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/placer_cell_addr.sv
// Cell index counter for a ship being placed; turns bow + direction + k into a
// board address and flags the last cell of the ship.
module placer_cell_addr
   import battleship_pkg::*;
#(
   parameter int CW = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [CW-1:0] bow_row_i,
   input  logic [CW-1:0] bow_col_i,
   input  logic          dir_i,
   input  logic [2:0]    len_i,
   input  logic          k_clr_i,
   input  logic          k_inc_i,
   output logic [CW-1:0] row_o,
   output logic [CW-1:0] col_o,
   output logic          last_o
);

   logic [2:0]    k_q, k_d;
   logic [CW-1:0] k_ext;

   always_comb begin
      k_d = k_q;
      if (k_clr_i) begin
         k_d = '0;
      end else if (k_inc_i) begin
         k_d = k_q + 3'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         k_q <= '0;
      end else begin
         k_q <= k_d;
      end
   end

   assign k_ext  = CW'(k_q);
   assign row_o  = dir_i ? (bow_row_i + k_ext) : bow_row_i;
   assign col_o  = dir_i ? bow_col_i : (bow_col_i + k_ext);
   assign last_o = (k_q == (len_i - 3'd1));

endmodule

// File: rtl/ship_placer.sv
// Places one ship per request: bounds check, overlap scan of the board, then
// board writes and a ship record. Optional reject counter under PLACER_STATS_EN.
module ship_placer
   import battleship_pkg::*;
#(
   parameter int BOARD_DIM = battleship_pkg::BOARD_DIM,
   parameter int COORD_W   = battleship_pkg::COORD_W,
   parameter int NUM_SHIPS = battleship_pkg::NUM_SHIPS
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [COORD_W-1:0] req_row,
   input  logic [COORD_W-1:0] req_col,
   input  logic               req_dir,
   output logic               resp_valid,
   output logic [1:0]         resp_code,
   output logic [2:0]         ship_idx,
   output logic               all_placed,
   output logic               gb_re,
   output logic               gb_we,
   output logic [COORD_W-1:0] gb_row,
   output logic [COORD_W-1:0] gb_col,
   output logic [1:0]         gb_wdata,
   input  logic [1:0]         gb_rdata,
   output logic               ss_we,
   output logic [2:0]         ss_addr,
   output logic [12:0]        ss_wdata
`ifdef PLACER_STATS_EN
   ,
   output logic [7:0]         rej_count
`endif
);

   localparam logic [COORD_W:0] BOARD_LIM = (COORD_W+1)'(BOARD_DIM);

   placer_state_e      state_q, state_d;
   resp_code_e         code_q, code_d;
   logic [2:0]         idx_q, idx_d;
   logic [COORD_W-1:0] row_q, col_q;
   logic               dir_q;

   logic               accept;
   logic [2:0]         len;
   logic               k_clr, k_inc, k_last;
   logic [COORD_W-1:0] cell_row, cell_col;
   logic [COORD_W:0]   far_end;
   logic               in_bounds;
   ship_rec_t          rec;

   assign len        = ship_len(idx_q);
   assign req_ready  = (state_q == ST_IDLE) && !clear;
   assign accept     = req_valid && req_ready;
   assign all_placed = (idx_q == 3'(NUM_SHIPS));

   // Far end is computed one bit wider so a wrap past 15 still reads as out of range.
   assign far_end   = (dir_q ? {1'b0, row_q} : {1'b0, col_q})
                      + (COORD_W+1)'(len) - (COORD_W+1)'(1);
   assign in_bounds = ({1'b0, row_q} < BOARD_LIM) && ({1'b0, col_q} < BOARD_LIM)
                      && (far_end < BOARD_LIM);

   placer_cell_addr #(
      .CW(COORD_W)
   ) u_cell_addr (
      .clk_i     (clk),
      .rst_ni    (reset),
      .bow_row_i (row_q),
      .bow_col_i (col_q),
      .dir_i     (dir_q),
      .len_i     (len),
      .k_clr_i   (k_clr),
      .k_inc_i   (k_inc),
      .row_o     (cell_row),
      .col_o     (cell_col),
      .last_o    (k_last)
   );

   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      idx_d      = idx_q;
      k_clr      = 1'b0;
      k_inc      = 1'b0;
      gb_re      = 1'b0;
      gb_we      = 1'b0;
      ss_we      = 1'b0;
      resp_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (clear) begin
               idx_d = '0;
            end else if (accept) begin
               if (all_placed) begin
                  code_d  = RESP_FULL;
                  state_d = ST_FULL_RESP;
               end else begin
                  state_d = ST_BOUNDS;
               end
            end
         end
         ST_FULL_RESP: begin
            resp_valid = 1'b1;
            state_d    = ST_IDLE;
         end
         ST_BOUNDS: begin
            k_clr = 1'b1;
            if (in_bounds) begin
               state_d = ST_RD;
            end else begin
               code_d  = RESP_OOB;
               state_d = ST_RESP;
            end
         end
         ST_RD: begin
            gb_re   = 1'b1;
            state_d = ST_CHK;
         end
         ST_CHK: begin
            if (gb_rdata == CELL_SHIP) begin
               code_d  = RESP_OVERLAP;
               state_d = ST_RESP;
            end else if (k_last) begin
               k_clr   = 1'b1;
               state_d = ST_WR;
            end else begin
               k_inc   = 1'b1;
               state_d = ST_RD;
            end
         end
         ST_WR: begin
            gb_we = 1'b1;
            if (k_last) begin
               state_d = ST_STORE;
            end else begin
               k_inc = 1'b1;
            end
         end
         ST_STORE: begin
            ss_we   = 1'b1;
            idx_d   = idx_q + 3'd1;
            code_d  = RESP_OK;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         code_q  <= RESP_OK;
         idx_q   <= '0;
         row_q   <= '0;
         col_q   <= '0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         idx_q   <= idx_d;
         if (accept) begin
            row_q <= req_row;
            col_q <= req_col;
            dir_q <= req_dir;
         end
      end
   end

   assign rec = '{row: 4'(row_q), col: 4'(col_q), dir: dir_q, hits: 3'b000, sunk: 1'b0};

   assign resp_code = code_q;
   assign ship_idx  = idx_q;
   assign gb_row    = (gb_re || gb_we) ? cell_row : '0;
   assign gb_col    = (gb_re || gb_we) ? cell_col : '0;
   assign gb_wdata  = CELL_SHIP;
   assign ss_addr   = ss_we ? idx_q : '0;
   assign ss_wdata  = rec;

`ifdef PLACER_STATS_EN
   logic [7:0] rej_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rej_q <= '0;
      end else if ((state_q == ST_IDLE) && clear) begin
         rej_q <= '0;
      end else if ((state_q == ST_RESP) && ((code_q == RESP_OOB) || (code_q == RESP_OVERLAP))
                   && (rej_q != 8'hFF)) begin
         rej_q <= rej_q + 8'd1;
      end
   end

   assign rej_count = rej_q;
`endif

endmodule

// File: tb/tb_ship_placer.sv
// Bench for ship_placer: directed table, randomized requests against a board-level
// model, clear / async-reset sequences, and the reject counter when enabled.
module tb_ship_placer;

   logic        clk;
   logic        reset;
   logic        clear;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_row, req_col;
   logic        req_dir;
   logic        resp_valid;
   logic [1:0]  resp_code;
   logic [2:0]  ship_idx;
   logic        all_placed;
   logic        gb_re, gb_we;
   logic [3:0]  gb_row, gb_col;
   logic [1:0]  gb_wdata;
   logic [1:0]  gb_rdata;
   logic        ss_we;
   logic [2:0]  ss_addr;
   logic [12:0] ss_wdata;
`ifdef PLACER_STATS_EN
   logic [7:0]  rej_count;
`endif

   ship_placer dut (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_row    (req_row),
      .req_col    (req_col),
      .req_dir    (req_dir),
      .resp_valid (resp_valid),
      .resp_code  (resp_code),
      .ship_idx   (ship_idx),
      .all_placed (all_placed),
      .gb_re      (gb_re),
      .gb_we      (gb_we),
      .gb_row     (gb_row),
      .gb_col     (gb_col),
      .gb_wdata   (gb_wdata),
      .gb_rdata   (gb_rdata),
      .ss_we      (ss_we),
      .ss_addr    (ss_addr),
      .ss_wdata   (ss_wdata)
`ifdef PLACER_STATS_EN
      ,
      .rej_count  (rej_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Board memory seen by the DUT, with a backdoor for preloading and wiping.
   logic [1:0] mem [10][10];
   logic       bd_we, bd_clr;
   int         bd_row, bd_col;
   logic [1:0] bd_data;

   always @(posedge clk) begin
      if (bd_clr) begin
         for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
               mem[r][c] <= 2'b00;
      end else if (bd_we) begin
         mem[bd_row][bd_col] <= bd_data;
      end else if (gb_we && int'(gb_row) < 10 && int'(gb_col) < 10) begin
         mem[int'(gb_row)][int'(gb_col)] <= gb_wdata;
      end
      if (gb_re && int'(gb_row) < 10 && int'(gb_col) < 10)
         gb_rdata <= mem[int'(gb_row)][int'(gb_col)];
   end

   int n_checks = 0;
   int n_errors = 0;
   int n_tx     = 0;

   // Reference model state
   int ref_board [10][10];
   int lens [5] = '{5, 4, 3, 3, 2};
   int m_placed;
   int exp_rej;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_predict(input int r, input int c, input int d,
                                output int code, output int lat, output int nrd);
      int len, fr, fc;
      code = 0; lat = 0; nrd = 0;
      if (m_placed >= 5) begin
         code = 3; lat = 1;
         return;
      end
      len = lens[m_placed];
      fr  = d ? r + len - 1 : r;
      fc  = d ? c : c + len - 1;
      if (r >= 10 || c >= 10 || fr >= 10 || fc >= 10) begin
         code = 1; lat = 2;
         return;
      end
      for (int k = 0; k < len; k++) begin
         nrd = k + 1;
         if (ref_board[r + d*k][c + (1-d)*k] == 3) begin
            code = 2; lat = 2*k + 4;
            return;
         end
      end
      code = 0; lat = 3*len + 3; nrd = len;
   endtask

   task automatic bd_write(input int r, input int c, input logic [1:0] v);
      @(negedge clk);
      bd_we = 1'b1; bd_row = r; bd_col = c; bd_data = v;
      @(posedge clk);
      #1 bd_we = 1'b0;
      ref_board[r][c] = int'(v);
   endtask

   task automatic wipe_board();
      @(negedge clk);
      bd_clr = 1'b1;
      @(posedge clk);
      #1 bd_clr = 1'b0;
      for (int r = 0; r < 10; r++)
         for (int c = 0; c < 10; c++)
            ref_board[r][c] = 0;
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      #1 chk("ready_during_clear", int'(req_ready), 0);
      @(posedge clk);
      #1 clear = 1'b0;
      m_placed = 0;
      exp_rej  = 0;
      @(negedge clk);
      chk("clear_ship_idx", int'(ship_idx), 0);
      chk("clear_all_placed", int'(all_placed), 0);
`ifdef PLACER_STATS_EN
      chk("clear_rej_count", int'(rej_count), 0);
`endif
      $display("clear: ship_idx=%0d all_placed=%0d", ship_idx, all_placed);
   endtask

   task automatic board_compare();
      int diff = 0;
      for (int r = 0; r < 10; r++)
         for (int c = 0; c < 10; c++)
            if (int'(mem[r][c]) != ref_board[r][c]) diff++;
      chk("board_cells_differing", diff, 0);
   endtask

   task automatic do_req(input int r, input int c, input int d, input int use_tbl,
                         input int t_code, input int t_lat, input int t_idx);
      int m_code, m_lat, m_nrd, len;
      int e_code, e_lat, e_idx, e_nwr;
      int rd_r[$], rd_c[$], wr_r[$], wr_c[$];
      int cyc, got, lat, code, excl, ready_bad, wdata_bad, ss_cnt, ss_d, ss_a, w;
      int rd_bad, wr_bad, old_idx;

      model_predict(r, c, d, m_code, m_lat, m_nrd);
      len     = (m_placed < 5) ? lens[m_placed] : 0;
      old_idx = m_placed;
      e_code  = use_tbl ? t_code : m_code;
      e_lat   = use_tbl ? t_lat  : m_lat;
      e_idx   = use_tbl ? t_idx  : (m_placed + ((m_code == 0) ? 1 : 0));
      e_nwr   = (m_code == 0) ? len : 0;

      @(negedge clk);
      req_row = 4'(r); req_col = 4'(c); req_dir = d[0]; req_valid = 1'b1;
      w = 0;
      while (!req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!req_ready) begin
         chk("accept_timeout", 0, 1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;

      cyc = 0; got = 0; lat = -1; code = -1; excl = 0; ready_bad = 0;
      wdata_bad = 0; ss_cnt = 0; ss_d = 0; ss_a = 0;
      while (!got && cyc < 80) begin
         @(negedge clk);
         cyc++;
         if (gb_re) begin rd_r.push_back(int'(gb_row)); rd_c.push_back(int'(gb_col)); end
         if (gb_we) begin
            wr_r.push_back(int'(gb_row)); wr_c.push_back(int'(gb_col));
            if (gb_wdata != 2'b11) wdata_bad++;
         end
         if (ss_we) begin ss_cnt++; ss_d = int'(ss_wdata); ss_a = int'(ss_addr); end
         if (int'(gb_re) + int'(gb_we) + int'(ss_we) > 1) excl++;
         if (req_ready) ready_bad++;
         if (resp_valid) begin got = 1; lat = cyc; code = int'(resp_code); end
      end
      chk("resp_seen", got, 1);
      chk("resp_code", code, e_code);
      chk("latency", lat, e_lat);
      chk("read_count", rd_r.size(), m_nrd);
      chk("write_count", wr_r.size(), e_nwr);
      rd_bad = 0;
      for (int k = 0; k < rd_r.size() && k < m_nrd; k++)
         if (rd_r[k] != r + d*k || rd_c[k] != c + (1-d)*k) rd_bad++;
      chk("read_addr", rd_bad, 0);
      wr_bad = 0;
      for (int k = 0; k < wr_r.size() && k < e_nwr; k++)
         if (wr_r[k] != r + d*k || wr_c[k] != c + (1-d)*k) wr_bad++;
      chk("write_addr", wr_bad, 0);
      chk("write_data", wdata_bad, 0);
      chk("one_enable", excl, 0);
      chk("ready_low_busy", ready_bad, 0);
      chk("ss_we_count", ss_cnt, (m_code == 0) ? 1 : 0);
      if (m_code == 0) begin
         chk("ss_wdata", ss_d, (r << 9) | (c << 5) | (d << 4));
         chk("ss_addr", ss_a, old_idx);
      end

      if (m_code == 0) begin
         for (int k = 0; k < len; k++) ref_board[r + d*k][c + (1-d)*k] = 3;
         m_placed++;
      end else if ((m_code == 1 || m_code == 2) && exp_rej < 255) begin
         exp_rej++;
      end

      @(negedge clk);
      chk("resp_pulse_len", int'(resp_valid), 0);
      chk("ready_after_resp", int'(req_ready), 1);
      chk("ship_idx", int'(ship_idx), e_idx);
      chk("all_placed", int'(all_placed), (e_idx == 5) ? 1 : 0);
`ifdef PLACER_STATS_EN
      chk("rej_count", int'(rej_count), exp_rej);
`endif
      board_compare();
      n_tx++;
      $display("req %0d: bow=(%0d,%0d) dir=%0d code=%0d lat=%0d ship_idx=%0d",
               n_tx, r, c, d, code, lat, ship_idx);
   endtask

   task automatic new_game();
      int n;
      do_clear();
      wipe_board();
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++)
         bd_write($urandom_range(0, 9), $urandom_range(0, 9), 2'($urandom_range(1, 2)));
   endtask

   typedef struct {
      int r; int c; int d;
      int code; int lat; int idx;
   } vec_t;

   vec_t tbl [10];

   initial begin
      int cyc, got_we;

      tbl[0] = '{0, 6, 0, 1, 2, 0};
      tbl[1] = '{10, 0, 0, 1, 2, 0};
      tbl[2] = '{2, 3, 0, 0, 18, 1};
      tbl[3] = '{0, 5, 1, 2, 8, 1};
      tbl[4] = '{5, 0, 1, 0, 15, 2};
      tbl[5] = '{9, 9, 0, 1, 2, 2};
      tbl[6] = '{7, 5, 0, 0, 12, 3};
      tbl[7] = '{0, 0, 0, 0, 12, 4};
      tbl[8] = '{9, 8, 0, 0, 9, 5};
      tbl[9] = '{4, 4, 0, 3, 1, 5};

      reset = 1'b0; clear = 1'b0; req_valid = 1'b0;
      req_row = '0; req_col = '0; req_dir = 1'b0;
      bd_we = 1'b0; bd_clr = 1'b0; bd_row = 0; bd_col = 0; bd_data = '0;
      m_placed = 0; exp_rej = 0;
      for (int r = 0; r < 10; r++)
         for (int c = 0; c < 10; c++)
            ref_board[r][c] = 0;

      bd_clr = 1'b1;
      repeat (3) @(negedge clk);
      bd_clr = 1'b0;
      chk("rst_resp_valid", int'(resp_valid), 0);
      chk("rst_ship_idx", int'(ship_idx), 0);
      chk("rst_enables", int'(gb_re) + int'(gb_we) + int'(ss_we), 0);
      chk("rst_addr", int'(gb_row) + int'(gb_col) + int'(ss_addr), 0);
      chk("rst_resp_code", int'(resp_code), 0);
      reset = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", int'(req_ready), 1);

      for (int i = 0; i < 10; i++)
         do_req(tbl[i].r, tbl[i].c, tbl[i].d, 1, tbl[i].code, tbl[i].lat, tbl[i].idx);

      // New game, then async reset in the middle of writing ship 2.
      do_clear();
      wipe_board();
      do_req(1, 1, 0, 1, 0, 18, 1);
      do_req(3, 0, 1, 1, 0, 15, 2);
      @(negedge clk);
      req_row = 4'd8; req_col = 4'd2; req_dir = 1'b0; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      cyc = 0; got_we = 0;
      while (!got_we && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (gb_we) got_we = 1;
      end
      chk("first_write_cycle", cyc, 8);
      reset = 1'b0;
      #1;
      chk("midrst_enables", int'(gb_re) + int'(gb_we) + int'(ss_we), 0);
      chk("midrst_resp_valid", int'(resp_valid), 0);
      chk("midrst_ship_idx", int'(ship_idx), 0);
      chk("midrst_addr", int'(gb_row) + int'(gb_col), 0);
      chk("midrst_resp_code", int'(resp_code), 0);
      $display("async reset during write: ship_idx=%0d gb_we=%0d", ship_idx, gb_we);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("ready_after_midrst", int'(req_ready), 1);
      m_placed = 0; exp_rej = 0;
      wipe_board();
      do_req(4, 4, 1, 0, 0, 0, 0);

`ifdef PLACER_STATS_EN
      do_clear();
      wipe_board();
      do_req(0, 9, 0, 1, 1, 2, 0);
      do_req(10, 0, 0, 1, 1, 2, 0);
      do_req(15, 15, 1, 1, 1, 2, 0);
      do_req(0, 0, 0, 1, 0, 18, 1);
      chk("stats_rej_after_seq", int'(rej_count), 3);
      do_clear();
`endif

      // Randomized games against the model.
      new_game();
      for (int i = 0; i < 40; i++) begin
         if (m_placed == 5 && $urandom_range(0, 2) != 0) new_game();
         else if ($urandom_range(0, 19) == 0) do_clear();
         do_req($urandom_range(0, 10), $urandom_range(0, 10), $urandom_range(0, 1), 0, 0, 0, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
